// File: rtl/bit_serializer_pkg.sv
// Shared constants for the bit serializer: FSM state encoding and default word width.
package bit_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ser_hold_reg.sv
// One-word holding register with full flag; parks the next word while the shifter is busy.
module ser_hold_reg
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] held_data,
  output logic             full
);

  // load wins over unload so a same-edge refill never drops the new word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_data <= '0;
      full      <= 1'b0;
    end else if (load) begin
      held_data <= load_data;
      full      <= 1'b1;
    end else if (unload) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: shift register plus one-word hold, registered serial outputs.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]    bit_cnt, cnt_nxt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, hold_load, hold_unload;
  logic             accept;
  logic             ser_out_nxt, ser_valid_nxt, frame_done_nxt;

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic head(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v[WIDTH-1];
    else           return v[0];
  endfunction

  // Ready only when the hold slot is free; forced low while reset is asserted
  assign data_ready = ~hold_full & ~reset;
  assign accept     = data_valid & data_ready;

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .unload    (hold_unload),
    .load_data (data_in),
    .held_data (hold_data),
    .full      (hold_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= cnt_nxt;
      ser_out    <= ser_out_nxt;
      ser_valid  <= ser_valid_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Next word comes from the hold slot first, else straight from data_in, so words chain gap-free
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    cnt_nxt     = bit_cnt;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_nxt = data_in;
          cnt_nxt   = LAST_IDX;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (hold_full) begin
            shift_nxt   = hold_data;
            cnt_nxt     = LAST_IDX;
            hold_unload = 1'b1;
          end else if (accept) begin
            shift_nxt = data_in;
            cnt_nxt   = LAST_IDX;
          end else begin
            shift_nxt = '0;
            state_nxt = IDLE;
          end
        end else begin
          shift_nxt = advance(shift_reg);
          cnt_nxt   = bit_cnt - CW'(1);
          hold_load = accept;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ser_valid_nxt  = (state_nxt == SHIFT);
    ser_out_nxt    = ser_valid_nxt & head(shift_nxt);
    frame_done_nxt = ser_valid_nxt & (cnt_nxt == '0);
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances against a queue-of-bits model.
module tb_bit_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_valid = 1'b0;
  logic [W-1:0] data_in = '0;

  logic m_ready, m_out, m_valid, m_done;
  logic l_ready, l_out, l_valid, l_done;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(m_ready), .ser_out(m_out), .ser_valid(m_valid), .frame_done(m_done)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(l_ready), .ser_out(l_out), .ser_valid(l_valid), .frame_done(l_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted word becomes W pending bits; the head bit is what is on the wire
  typedef struct packed {
    logic msb_bit;
    logic lsb_bit;
    logic last;
  } slot_t;

  slot_t q[$];
  int    acc_cnt = 0;
  bit    can_take;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      can_take = (q.size() <= W);
      if (q.size() > 0) void'(q.pop_front());
      if (data_valid && can_take) begin
        for (int i = 0; i < W; i++)
          q.push_back('{msb_bit: data_in[W-1-i], lsb_bit: data_in[i], last: (i == W - 1)});
        acc_cnt++;
      end
    end
  end

  logic [63:0] mstream = '0;
  logic [63:0] lstream = '0;
  int          fd_total = 0;
  int          run = 0;
  int          last_run = 0;
  logic        e_valid, e_ready, e_m, e_l, e_last;

  always @(negedge clk) begin
    e_valid = (q.size() > 0);
    e_ready = !reset && (q.size() <= W);
    e_m     = e_valid ? q[0].msb_bit : 1'b0;
    e_l     = e_valid ? q[0].lsb_bit : 1'b0;
    e_last  = e_valid ? q[0].last : 1'b0;
    chk("msb.data_ready", m_ready, e_ready);
    chk("msb.ser_valid", m_valid, e_valid);
    chk("msb.ser_out", m_out, e_m);
    chk("msb.frame_done", m_done, e_last);
    chk("lsb.data_ready", l_ready, e_ready);
    chk("lsb.ser_valid", l_valid, e_valid);
    chk("lsb.ser_out", l_out, e_l);
    chk("lsb.frame_done", l_done, e_last);
    if (m_valid) mstream = {mstream[62:0], m_out};
    if (l_valid) lstream = {l_out, lstream[63:1]};
    if (m_done) fd_total++;
    if (m_valid) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    int base;
    base = acc_cnt;
    data_in    = w;
    data_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc_cnt != base) break;
    end
    data_valid = 1'b0;
    chk("push_accepted", 32'(acc_cnt != base), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (!m_valid && q.size() == 0) break;
      tick();
    end
    chk("idle_reached", 32'(m_valid), 32'd0);
  endtask

  int          fd_base;
  int          base3;
  logic [7:0]  pin_vec;
  logic [7:0]  words3 [3];
  int          pct;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset.ser_valid", m_valid, 1'b0);
    chk("reset.data_ready", m_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_reset.data_ready", m_ready, 1'b1);
    tick();

    // 8'hA5: MSB instance emits 10100101, LSB instance its mirror, frame_done once
    fd_base = fd_total;
    push_word(8'hA5);
    chk("model.size_after_accept", q.size(), 32'd8);
    for (int i = 0; i < 8; i++) pin_vec[7-i] = q[i].msb_bit;
    chk("model.msb_order", pin_vec, 8'hA5);
    wait_idle();
    chk("a5.msb_stream", mstream[7:0], 8'hA5);
    chk("a5.lsb_stream", lstream[63:56], 8'hA5);
    chk("a5.frame_done_count", fd_total - fd_base, 32'd1);
    chk("a5.run_length", last_run, 32'd8);

    // 8'hFF then 8'h00 back-to-back: 16 contiguous bits, ready low while held
    push_word(8'hFF);
    push_word(8'h00);
    chk("ff00.ready_while_held", m_ready, 1'b0);
    wait_idle();
    chk("ff00.run_length", last_run, 32'd16);
    chk("ff00.msb_stream", mstream[15:0], 16'hFF00);

    // 8'h01: LSB-first puts the 1 first
    push_word(8'h01);
    chk("01.lsb_first_bit", l_out, 1'b1);
    wait_idle();
    chk("01.lsb_stream", lstream[63:56], 8'h01);
    chk("01.msb_stream", mstream[7:0], 8'h01);

    // Reset after the 3rd bit of 8'hF0, then 8'h80 must come out cleanly
    push_word(8'hF0);
    tick();
    tick();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset.ser_valid", m_valid, 1'b0);
    chk("midreset.lsb_ser_valid", l_valid, 1'b0);
    chk("midreset.data_ready", m_ready, 1'b0);
    tick();
    chk("midreset.partial_run", last_run, 32'd3);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset.ready_after", m_ready, 1'b1);
    tick();
    push_word(8'h80);
    wait_idle();
    chk("80.msb_stream", mstream[7:0], 8'h80);
    chk("80.lsb_stream", lstream[63:56], 8'h80);
    chk("80.run_length", last_run, 32'd8);

    // 8'h20: single 1 at the bit-5 position
    push_word(8'h20);
    wait_idle();
    chk("20.msb_stream", mstream[7:0], 8'h20);

    // data_valid held for three words while data_ready toggles
    words3[0] = 8'h3C;
    words3[1] = 8'hC3;
    words3[2] = 8'h5A;
    fd_base = fd_total;
    base3   = acc_cnt;
    data_valid = 1'b1;
    data_in    = words3[0];
    for (int i = 0; i < 80; i++) begin
      tick();
      if (acc_cnt - base3 >= 3) break;
      data_in = words3[acc_cnt - base3];
    end
    data_valid = 1'b0;
    chk("three.accepted", acc_cnt - base3, 32'd3);
    wait_idle();
    chk("three.frame_done_count", fd_total - fd_base, 32'd3);
    chk("three.msb_stream", mstream[23:0], 24'h3CC35A);
    chk("three.lsb_stream", lstream[63:40], 24'h5AC33C);

    // Randomized traffic with varying load and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 20;
          1:       pct = 60;
          default: pct = 95;
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
      end
      tick();
      data_valid = ($urandom_range(0, 99) < pct);
      data_in    = W'($urandom);
    end
    data_valid = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port data_in, input, WIDTH bits: parallel word to serialize.
REQ-006 The module SHALL have port data_valid, input, 1 bit: data_in is valid this cycle.
REQ-007 The module SHALL have port data_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 The module SHALL have port ser_out, output, 1 bit: serial bit, the "in" feed of the downstream sample detector.
REQ-009 The module SHALL have port ser_valid, output, 1 bit: ser_out carries a word bit this cycle.
REQ-010 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last bit of a word.

Function
REQ-011 A word SHALL be accepted on a rising edge where data_valid and data_ready are both 1; there is no other transfer condition.
REQ-012 Storage SHALL be a shift register plus one holding register, giving 2-word capacity.
REQ-013 data_ready SHALL be 1 exactly when the holding register is empty, decoded combinationally from registered state.
REQ-014 The FSM SHALL have two states: IDLE (nothing shifting) and SHIFT (a word is being emitted).
REQ-015 In IDLE, an accepted word SHALL load the shift register directly, set bit_cnt to WIDTH-1, and move to SHIFT.
REQ-016 In SHIFT, an accepted word SHALL go into the holding register.
REQ-017 Latency: a word accepted at edge N SHALL present its first bit on ser_out with ser_valid=1 from edge N+1.
REQ-018 In SHIFT, one bit SHALL be emitted per cycle and bit_cnt SHALL decrement by 1 per cycle.
REQ-019 At bit_cnt==0, frame_done SHALL be 1.
REQ-020 At bit_cnt==0 with the holding register full, the held word SHALL load at the next edge with no gap cycle and the state SHALL stay SHIFT.
REQ-021 At bit_cnt==0 with the holding register empty and no word accepted that edge, the state SHALL move to IDLE.
REQ-022 At bit_cnt==0 with the holding register empty and a word accepted that same edge, that word SHALL load directly into the shift register (no gap cycle).
REQ-023 Simultaneous accept and holding-register unload on one edge SHALL lose no word.
REQ-024 In IDLE, ser_out, ser_valid and frame_done SHALL be 0, so the downstream detector sees 0 samples.
REQ-025 ser_out, ser_valid and frame_done SHALL be driven from registers; there is no combinational path from data_in to ser_out.
REQ-026 bit_cnt SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, clear both storage registers and bit_cnt, and set ser_out=0, ser_valid=0, frame_done=0.
REQ-028 While reset is high, data_ready SHALL be 0.
REQ-029 data_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 A reset mid-word SHALL discard the partial word and any held word; no bit of either SHALL appear after reset.

Structure
REQ-031 The IDLE/SHIFT state encodings (IDLE=0, SHIFT=1) and the WIDTH default SHALL live in the shared constants package/header used by the FSM blocks.
REQ-032 The holding register with its full flag SHALL be a sub-module named ser_hold_reg; everything else SHALL be flat in bit_serializer.

Verification
REQ-033 Scenario: 8'hA5 with MSB_FIRST=1 -> ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles, and frame_done on the 8th cycle only.
REQ-034 Scenario: 8'hFF then 8'h00 presented back-to-back -> 16 contiguous ser_valid cycles, data_ready low while the hold is full, then a return to IDLE.
REQ-035 Scenario: 8'h01 with MSB_FIRST=0 -> first ser_out bit is 1 and the next seven are 0.
REQ-036 Scenario: reset asserted after the 3rd bit of 8'hF0 -> ser_valid drops immediately, and the next word 8'h80 emits cleanly from its first bit.
REQ-037 Scenario: 8'h20 chained into the downstream detector -> detector out high for exactly 3 samples after the bit-5 sample.
REQ-038 Scenario: data_valid held high for 3 words while data_ready toggles -> exactly 3 words are serialized, with no duplicates and no drops.
